// File: rtl/a2d_spi_resp_if.sv
// SPI bus between the A2D master and the a2d_spi_resp responder.
// master: drives SS_n/SCLK/MOSI, receives MISO.
// slave:  receives SS_n/SCLK/MOSI, drives MISO.
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder for the A2D command/response protocol.
// Receives {2'b00, chnnl[2:0], 11'h000} MSB first and, in the same frame,
// returns the zero-extended result of the channel latched by the previous
// frame. All SPI pins are oversampled on clk; no logic runs on SCLK.
// Optional feature macro: A2D_DITHER_EN adds an LFSR dither (-2..+1, saturated)
// to the loaded result.
module a2d_spi_resp #(
  parameter int SYNC_STAGES = 2,
  parameter int RES_W       = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  a2d_spi_resp_if.slave      spi,
  input  logic [8*RES_W-1:0] ana_vals,
  output logic               cmd_rcvd,
  output logic [2:0]         chnnl_rcvd,
  output logic               cmd_err,
  output logic               frm_err
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Synchronizer chains plus one extra flop each for edge detection
  logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_ss_d, r_sclk_d;
  logic                   w_ss_s, w_sclk_s, w_mosi_s;
  logic                   w_ss_fall, w_ss_rise, w_sclk_fall, w_sclk_rise;

  // Frame state
  state_t      r_state, w_state_next;
  logic [4:0]  r_bit_cnt, w_bit_cnt_next;
  logic [15:0] r_rx_shf, w_rx_shf_next;
  logic [15:0] r_tx_shf, w_tx_shf_next;
  logic        r_seen_rise, w_seen_rise_next;
  logic [2:0]  r_chnnl, w_chnnl_next;
  logic        r_cmd_rcvd, w_cmd_rcvd_next;
  logic        r_cmd_err, w_cmd_err_next;
  logic        r_frm_err, w_frm_err_next;
  logic        r_miso, w_miso_next;

  logic [RES_W-1:0] w_ana_sel;
  logic [RES_W-1:0] w_result;
  logic [15:0]      w_tx_load;

  // Pins are sampled into idle-level-reset synchronizers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '1;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi.SS_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      r_ss_d      <= w_ss_s;
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_fall   = r_ss_d & ~w_ss_s;
  assign w_ss_rise   = ~r_ss_d & w_ss_s;
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_sclk_rise = ~r_sclk_d & w_sclk_s;

  assign w_ana_sel = ana_vals[RES_W*r_chnnl +: RES_W];

`ifdef A2D_DITHER_EN
  logic [15:0]      r_lfsr;
  logic [RES_W+1:0] w_dith_sum;

  // Fibonacci LFSR (taps 16,14,13,11) steps once per frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_ss_fall) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Two guard bits: top bit flags underflow, next bit flags overflow
  assign w_dith_sum = {2'b00, w_ana_sel} + {{RES_W{r_lfsr[1]}}, r_lfsr[1:0]};

  // Clamp the dithered value into the result range
  always_comb begin
    if (w_dith_sum[RES_W+1])
      w_result = '0;
    else if (w_dith_sum[RES_W])
      w_result = '1;
    else
      w_result = w_dith_sum[RES_W-1:0];
  end
`else
  assign w_result = w_ana_sel;
`endif

  assign w_tx_load = {{(16-RES_W){1'b0}}, w_result};

  // Frame state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_shf    <= '0;
      r_tx_shf    <= '0;
      r_seen_rise <= 1'b0;
      r_chnnl     <= '0;
      r_cmd_rcvd  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_rx_shf    <= w_rx_shf_next;
      r_tx_shf    <= w_tx_shf_next;
      r_seen_rise <= w_seen_rise_next;
      r_chnnl     <= w_chnnl_next;
      r_cmd_rcvd  <= w_cmd_rcvd_next;
      r_cmd_err   <= w_cmd_err_next;
      r_frm_err   <= w_frm_err_next;
      r_miso      <= w_miso_next;
    end
  end

  // Next-state: load on SS_n fall, shift on SCLK edges, commit on SS_n rise
  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_rx_shf_next    = r_rx_shf;
    w_tx_shf_next    = r_tx_shf;
    w_seen_rise_next = r_seen_rise;
    w_chnnl_next     = r_chnnl;
    w_cmd_rcvd_next  = 1'b0;
    w_cmd_err_next   = r_cmd_err;
    w_frm_err_next   = r_frm_err;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_tx_shf_next    = w_tx_load;
          w_bit_cnt_next   = '0;
          w_seen_rise_next = 1'b0;
          w_state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_state_next = IDLE;
          if (r_bit_cnt == 5'd16) begin
            // Channel is latched even for a malformed command
            w_chnnl_next    = r_rx_shf[13:11];
            w_cmd_rcvd_next = 1'b1;
            if ((r_rx_shf[15:14] != 2'b00) || (r_rx_shf[10:0] != 11'h000))
              w_cmd_err_next = 1'b1;
          end else begin
            w_frm_err_next = 1'b1;
          end
        end else begin
          if (w_sclk_rise && (r_bit_cnt < 5'd16)) begin
            w_rx_shf_next    = {r_rx_shf[14:0], w_mosi_s};
            w_bit_cnt_next   = r_bit_cnt + 5'd1;
            w_seen_rise_next = 1'b1;
          end
          // MSB is already on MISO before the first fall, so that fall is skipped
          if (w_sclk_fall && r_seen_rise && (r_bit_cnt < 5'd16))
            w_tx_shf_next = {r_tx_shf[14:0], 1'b0};
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_miso_next = (w_state_next == SHIFT) ? w_tx_shf_next[15] : 1'b0;
  end

  assign spi.MISO   = r_miso;
  assign cmd_rcvd   = r_cmd_rcvd;
  assign chnnl_rcvd = r_chnnl;
  assign cmd_err    = r_cmd_err;
  assign frm_err    = r_frm_err;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: drives SPI frames as the A2D master
// (SCLK half-period of 8 clks) and checks responses and status outputs.
module tb_a2d_spi_resp;
  localparam int RES_W = 12;
  localparam int HALF  = 8;

  logic             clk;
  logic             rst_n;
  logic [8*RES_W-1:0] ana_vals;
  logic             cmd_rcvd;
  logic [2:0]       chnnl_rcvd;
  logic             cmd_err;
  logic             frm_err;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  a2d_spi_resp_if spi ();

  a2d_spi_resp #(.SYNC_STAGES(2), .RES_W(RES_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi.slave),
    .ana_vals   (ana_vals),
    .cmd_rcvd   (cmd_rcvd),
    .chnnl_rcvd (chnnl_rcvd),
    .cmd_err    (cmd_err),
    .frm_err    (frm_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_rcvd) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [RES_W-1:0] v);
    ana_vals[RES_W*ch +: RES_W] = v;
  endtask

  // One master frame of nbits SCLK cycles; optionally rewrites ch3 at bit chg_bit
  task automatic spi_frame(input logic [15:0] mosi_word, input int nbits,
                           input int chg_bit, input logic [RES_W-1:0] chg_val,
                           output logic [15:0] miso_word);
    miso_word = '0;
    spi.SS_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = mosi_word[15-i];
      if (i == chg_bit) set_ch(3, chg_val);
      wait_clks(HALF);
      miso_word[15-i] = spi.MISO;
      spi.SCLK = 1'b1;
      wait_clks(HALF);
    end
    spi.SS_n = 1'b1;
    spi.MOSI = 1'b0;
    wait_clks(HALF + 2);
    $display("frame mosi=%h bits=%0d miso=%h chnnl=%0d cmd_err=%b frm_err=%b",
             mosi_word, nbits, miso_word, chnnl_rcvd, cmd_err, frm_err);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clks(4);
    checks++; if (spi.MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi.MISO); end
    checks++; if (cmd_rcvd !== 1'b0) begin failures++; $display("FAIL reset_cmd_rcvd got=%b exp=0", cmd_rcvd); end
    checks++; if (chnnl_rcvd !== 3'd0) begin failures++; $display("FAIL reset_chnnl got=%0d exp=0", chnnl_rcvd); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
    checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL reset_frm_err got=%b exp=0", frm_err); end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_basic;
    logic [15:0] w;
    int base;
    base = pulse_cnt;
    spi_frame(16'h1800, 16, -1, '0, w);
    checks++; if (w !== 16'h0111) begin failures++; $display("FAIL basic_f1_miso got=%h exp=0111", w); end
    checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL basic_f1_pulse got=%0d exp=1", pulse_cnt - base); end
    checks++; if (chnnl_rcvd !== 3'd3) begin failures++; $display("FAIL basic_f1_chnnl got=%0d exp=3", chnnl_rcvd); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL basic_f1_cmd_err got=%b exp=0", cmd_err); end
    spi_frame(16'h1800, 16, -1, '0, w);
    checks++; if (w !== 16'h0ABC) begin failures++; $display("FAIL basic_f2_miso got=%h exp=0abc", w); end
    checks++; if (chnnl_rcvd !== 3'd3) begin failures++; $display("FAIL basic_f2_chnnl got=%0d exp=3", chnnl_rcvd); end
  endtask

  task automatic test_ch7;
    logic [15:0] w;
    spi_frame(16'h3800, 16, -1, '0, w);
    checks++; if (w !== 16'h0ABC) begin failures++; $display("FAIL ch7_f1_miso got=%h exp=0abc", w); end
    checks++; if (chnnl_rcvd !== 3'd7) begin failures++; $display("FAIL ch7_chnnl got=%0d exp=7", chnnl_rcvd); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL ch7_cmd_err got=%b exp=0", cmd_err); end
    spi_frame(16'h1800, 16, -1, '0, w);
    checks++; if (w !== 16'h0FFF) begin failures++; $display("FAIL ch7_f2_miso got=%h exp=0fff", w); end
  endtask

  task automatic test_cmd_err;
    logic [15:0] w;
    int base;
    base = pulse_cnt;
    spi_frame(16'h9800, 16, -1, '0, w);
    checks++; if (w !== 16'h0ABC) begin failures++; $display("FAIL cerr_miso got=%h exp=0abc", w); end
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL cerr_flag got=%b exp=1", cmd_err); end
    checks++; if (chnnl_rcvd !== 3'd3) begin failures++; $display("FAIL cerr_chnnl got=%0d exp=3", chnnl_rcvd); end
    checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL cerr_pulse got=%0d exp=1", pulse_cnt - base); end
    spi_frame(16'h3800, 16, -1, '0, w);
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL cerr_sticky got=%b exp=1", cmd_err); end
    checks++; if (chnnl_rcvd !== 3'd7) begin failures++; $display("FAIL cerr_next_chnnl got=%0d exp=7", chnnl_rcvd); end
  endtask

  task automatic test_frm_err;
    logic [15:0] w;
    int base;
    base = pulse_cnt;
    spi_frame(16'h0800, 9, -1, '0, w);
    checks++; if (frm_err !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", frm_err); end
    checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL ferr_no_pulse got=%0d exp=0", pulse_cnt - base); end
    checks++; if (chnnl_rcvd !== 3'd7) begin failures++; $display("FAIL ferr_chnnl got=%0d exp=7", chnnl_rcvd); end
    base = pulse_cnt;
    spi_frame(16'h1800, 16, -1, '0, w);
    checks++; if (w !== 16'h0FFF) begin failures++; $display("FAIL ferr_next_miso got=%h exp=0fff", w); end
    checks++; if (chnnl_rcvd !== 3'd3) begin failures++; $display("FAIL ferr_next_chnnl got=%0d exp=3", chnnl_rcvd); end
    checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL ferr_next_pulse got=%0d exp=1", pulse_cnt - base); end
    checks++; if (frm_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frm_err); end
  endtask

  task automatic test_mid_change;
    logic [15:0] w;
    set_ch(3, 12'h123);
    spi_frame(16'h1800, 16, 5, 12'h456, w);
    checks++; if (w !== 16'h0123) begin failures++; $display("FAIL midchg_cur got=%h exp=0123", w); end
    spi_frame(16'h1800, 16, -1, '0, w);
    checks++; if (w !== 16'h0456) begin failures++; $display("FAIL midchg_next got=%h exp=0456", w); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    int base;
    spi.SS_n = 1'b0;
    wait_clks(HALF);
    repeat (5) begin
      spi.SCLK = 1'b0; wait_clks(HALF);
      spi.SCLK = 1'b1; wait_clks(HALF);
    end
    spi.SCLK = 1'b0;
    wait_clks(HALF);
    rst_n = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    wait_clks(1);
    rst_n = 1'b1;
    wait_clks(HALF + 2);
    $display("reset mid-frame chnnl=%0d cmd_err=%b frm_err=%b", chnnl_rcvd, cmd_err, frm_err);
    checks++; if (spi.MISO !== 1'b0) begin failures++; $display("FAIL rstmid_miso got=%b exp=0", spi.MISO); end
    checks++; if (chnnl_rcvd !== 3'd0) begin failures++; $display("FAIL rstmid_chnnl got=%0d exp=0", chnnl_rcvd); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL rstmid_cmd_err got=%b exp=0", cmd_err); end
    checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL rstmid_frm_err got=%b exp=0", frm_err); end
    base = pulse_cnt;
    spi_frame(16'h1800, 16, -1, '0, w);
    checks++; if (w !== 16'h0111) begin failures++; $display("FAIL rstmid_next_miso got=%h exp=0111", w); end
    checks++; if (chnnl_rcvd !== 3'd3) begin failures++; $display("FAIL rstmid_next_chnnl got=%0d exp=3", chnnl_rcvd); end
    checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL rstmid_next_pulse got=%0d exp=1", pulse_cnt - base); end
    checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL rstmid_next_frm_err got=%b exp=0", frm_err); end
  endtask

  task automatic test_extremes;
    logic [15:0] w;
    logic ok;
    set_ch(0, 12'h000);
    set_ch(7, 12'hFFF);
    spi_frame(16'h3800, 16, -1, '0, w);
    spi_frame(16'h0000, 16, -1, '0, w);
`ifdef A2D_DITHER_EN
    ok = (w >= 16'h0FFD) && (w <= 16'h0FFF);
`else
    ok = (w === 16'h0FFF);
`endif
    checks++; if (!ok) begin failures++; $display("FAIL extreme_hi got=%h exp=0fff_range", w); end
    checks++; if (chnnl_rcvd !== 3'd0) begin failures++; $display("FAIL extreme_chnnl got=%0d exp=0", chnnl_rcvd); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL extreme_cmd_err got=%b exp=0", cmd_err); end
    spi_frame(16'h0000, 16, -1, '0, w);
`ifdef A2D_DITHER_EN
    ok = (w <= 16'h0001);
`else
    ok = (w === 16'h0000);
`endif
    checks++; if (!ok) begin failures++; $display("FAIL extreme_lo got=%h exp=0000_range", w); end
  endtask

  initial begin
    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    ana_vals = '0;
    set_ch(0, 12'h111);
    set_ch(1, 12'h222);
    set_ch(2, 12'h333);
    set_ch(3, 12'hABC);
    set_ch(4, 12'h555);
    set_ch(5, 12'h666);
    set_ch(6, 12'h777);
    set_ch(7, 12'hFFF);
    wait_clks(2);
    test_reset;
    test_basic;
    test_ch7;
    test_cmd_err;
    test_frm_err;
    test_mid_change;
    test_reset_mid;
    test_extremes;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- SPI slave (responder) that answers the A2D command/response protocol; the counterpart of the A2D master interface.
- Used as the A2D-side model in system benches. Also usable as a drop-in responder when the analog front end is stubbed.
- Shifts in a 16-bit command {2'b00, chnnl[2:0], 11'h000} MSB first. On the same frame it shifts out {4'h0, result[11:0]} for the channel latched by the previous frame.
- Oversamples SCLK/SS_n/MOSI on the system clock; contains no SCLK-domain logic.

Parameters:
SYNC_STAGES, 2, metastability flops on SS_n/SCLK/MOSI before edge detect (min 2)
RES_W, 12, result width; upper 16-RES_W bits of response are 0

Ports:
clk  in  1  system clock (50MHz)
rst_n  in  1  synchronous active-low reset
SS_n  in  1  active-low slave select from master
SCLK  in  1  SPI clock from master, idles high
MOSI  in  1  serial command from master
MISO  out  1  serial response to master
ana_vals  in  8*RES_W  eight channel values, channel k at [RES_W*k +: RES_W]
cmd_rcvd  out  1  one-clk pulse when a complete valid frame is committed
chnnl_rcvd  out  3  channel latched from last committed frame
cmd_err  out  1  sticky: committed frame had nonzero bits [15:14] or [10:0]
frm_err  out  1  sticky: SS_n rose with bit count != 16

Behaviour:
- Reset is sampled only on posedge clk.
- Reset values: MISO=0, cmd_rcvd=0, chnnl_rcvd=0, cmd_err=0, frm_err=0. State=IDLE, bit_cnt=0, shift regs=0.
- Sync flops reset to idle levels: SS_n=1, SCLK=1, MOSI=0.
- Edge detect compares the last sync stage with one extra flop.
- sclk_rise/sclk_fall/ss_fall/ss_rise are single-cycle strobes, asserted SYNC_STAGES+1 clks after the pin edge.
- State machine is IDLE -> SHIFT -> IDLE.
- IDLE:
  - MISO held 0.
  - On ss_fall: load tx_shf = {(16-RES_W)'b0, ana_vals[chnnl_rcvd]}, clear bit_cnt, clear seen_rise, go SHIFT.
  - MISO=tx_shf[15] from the next clk.
- SHIFT, on sclk_rise (bit_cnt<16):
  - rx_shf = {rx_shf[14:0], MOSI_sync}.
  - bit_cnt++.
  - Set seen_rise.
- SHIFT, on sclk_fall:
  - If seen_rise and bit_cnt<16: tx_shf <<= 1, so MISO=tx_shf[15] updates on the next clk.
  - The first fall after SS_n low does not shift.
- SHIFT: rises beyond 16 are ignored; bit_cnt saturates at 16.
- SHIFT, on ss_rise: go IDLE, MISO=0.
  - If bit_cnt==16: chnnl_rcvd<=rx_shf[13:11] and cmd_rcvd pulses 1 clk. If rx_shf[15:14]!=0 or rx_shf[10:0]!=0, set cmd_err; channel is still latched.
  - If bit_cnt!=16: set frm_err; chnnl_rcvd unchanged; no cmd_rcvd.
- ss_fall while in SHIFT is impossible; it is ignored.
- The response value is sampled once at ss_fall. Changes to ana_vals mid-frame do not affect the frame in flight.
- The first frame after reset returns channel 0 data.
- Back-to-back frames (SS_n high for 1 SPI clk period) must be handled as long as SS_n high lasts ≥ SYNC_STAGES+2 clks.
- Reset asserted mid-frame aborts the frame. No error flag is set and chnnl_rcvd returns to 0.
- Sticky errors clear only on reset.
- Master timing: SCLK half-period ≥ 4 clks.

Optional Feature:
- Macro: A2D_DITHER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) that advances on every ss_fall.
  - Loaded result = ana_vals[ch] + sign-extended {lfsr[1],lfsr[0]} (range -2..+1).
  - The sum saturates to 0 and to 2^RES_W-1.
- Not defined: no LFSR hardware; the result is the exact ana_vals value.

Test Plan:
- ana_vals ch3=12'hABC. Frame 1 MOSI=16'h1800, then frame 2 MOSI=16'h1800. Expect:
  - frame 1: MISO shows ch0 value, cmd_rcvd pulse, chnnl_rcvd=3;
  - frame 2: MISO=16'h0ABC.
- Frame with MOSI=16'h3800 (chnnl 7) -> chnnl_rcvd=7, cmd_err stays 0. Next frame returns ana_vals ch7 = 12'hFFF as 16'h0FFF.
- Frame MOSI=16'h9800 -> cmd_err=1 (sticky), chnnl_rcvd=3, cmd_rcvd still pulses.
- SS_n raised after 9 SCLK rises -> frm_err=1, no cmd_rcvd, chnnl_rcvd unchanged. The next full frame works normally.
- Change ch3 from 12'h123 to 12'h456 mid-frame -> current frame returns 16'h0123; the following frame returns 16'h0456.
- Assert rst_n low for 1 clk mid-frame -> MISO=0, chnnl_rcvd=0, errors 0. The next frame returns ch0 data.
- With A2D_DITHER_EN, ch value 12'h000 and 12'hFFF -> returned values stay within 0..1 and FFD..FFF (saturation holds).
